// File: rtl/instruction_decode_queue_if.sv
// Fetch/register-file/execute bundle for the instruction decode queue.
// The queue sees the slave view; the fetch/execute side drives the master view.
interface instruction_decode_queue_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     inst;
   logic [XLEN-1:0] curr_pc;
   logic [4:0]      rs1_sel;
   logic [4:0]      rs2_sel;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_imm;
   logic [XLEN-1:0] out_rs1_data;
   logic [XLEN-1:0] out_rs2_data;
   logic [4:0]      out_rd_sel;
   logic [2:0]      out_funct3;
   logic            out_funct7b5;
   logic [3:0]      out_opclass;
   logic [15:0]     illegal_cnt;

   modport slave (
      input  in_valid, inst, curr_pc, rs1_data, rs2_data, flush, out_ready,
      output in_ready, rs1_sel, rs2_sel, out_valid, out_pc, out_imm,
             out_rs1_data, out_rs2_data, out_rd_sel, out_funct3, out_funct7b5,
             out_opclass, illegal_cnt
   );

   modport master (
      output in_valid, inst, curr_pc, rs1_data, rs2_data, flush, out_ready,
      input  in_ready, rs1_sel, rs2_sel, out_valid, out_pc, out_imm,
             out_rs1_data, out_rs2_data, out_rd_sel, out_funct3, out_funct7b5,
             out_opclass, illegal_cnt
   );
endinterface

// File: rtl/instruction_decode_queue.sv
// RV32/RV64 decode stage: classifies the offered instruction, reads operands,
// and holds decoded entries in a small in-order queue for the execute stage.
module instruction_decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int RV_M  = 0
) (
   input logic clk,
   input logic rst_n,
   instruction_decode_queue_if.slave io
);

   // Handshake: a side transfers on a cycle where its valid and ready are both
   // high at the rising edge; flush overrides both transfers in its cycle.

   typedef enum logic [3:0] {
      OPC_OP       = 4'd0,
      OPC_OP_IMM   = 4'd1,
      OPC_LUI      = 4'd2,
      OPC_AUIPC    = 4'd3,
      OPC_JAL      = 4'd4,
      OPC_JALR     = 4'd5,
      OPC_BRANCH   = 4'd6,
      OPC_LOAD     = 4'd7,
      OPC_STORE    = 4'd8,
      OPC_MISC_MEM = 4'd9,
      OPC_SYSTEM   = 4'd10,
      OPC_MULDIV   = 4'd11,
      OPC_ILLEGAL  = 4'd15
   } opclass_e;

   localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
   localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

   logic [6:0]        f7;
   logic [2:0]        f3;
   opclass_e          dec_class;
   logic signed [31:0] dec_imm32;
   logic [XLEN-1:0]   dec_imm;
   logic [4:0]        dec_rd;
   logic [2:0]        dec_f3;
   logic              dec_f7b5;

   logic [2:0]        count_q, count_d;
   logic [1:0]        head_q, head_d;
   logic [1:0]        tail_q, tail_d;
   logic [15:0]       illegal_cnt_q, illegal_cnt_d;
   logic              out_valid;
   logic              push;
   logic              pop;

   logic [XLEN-1:0]   pc_q   [4];
   logic [XLEN-1:0]   imm_q  [4];
   logic [XLEN-1:0]   rs1d_q [4];
   logic [XLEN-1:0]   rs2d_q [4];
   logic [4:0]        rd_q   [4];
   logic [2:0]        f3_q   [4];
   logic              f7b5_q [4];
   logic [3:0]        cls_q  [4];

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   assign f7 = io.inst[31:25];
   assign f3 = io.inst[14:12];

   always_comb begin
      dec_class = OPC_ILLEGAL;
      if (io.inst[1:0] == 2'b11) begin
         case (io.inst[6:2])
            5'b01100: begin
               case (f7)
                  7'h00:   dec_class = OPC_OP;
                  7'h20:   dec_class = (f3 == 3'b000 || f3 == 3'b101) ? OPC_OP : OPC_ILLEGAL;
                  7'h01:   dec_class = (RV_M != 0) ? OPC_MULDIV : OPC_ILLEGAL;
                  default: dec_class = OPC_ILLEGAL;
               endcase
            end
            5'b00100: dec_class = OPC_OP_IMM;
            5'b01101: dec_class = OPC_LUI;
            5'b00101: dec_class = OPC_AUIPC;
            5'b11011: dec_class = OPC_JAL;
            5'b11001: dec_class = OPC_JALR;
            5'b11000: dec_class = OPC_BRANCH;
            5'b00000: dec_class = OPC_LOAD;
            5'b01000: dec_class = OPC_STORE;
            5'b00011: dec_class = OPC_MISC_MEM;
            5'b11100: dec_class = OPC_SYSTEM;
            default:  dec_class = OPC_ILLEGAL;
         endcase
      end
   end

   // Immediates are assembled at 32 bits and sign-extended once to XLEN.
   always_comb begin
      dec_imm32 = '0;
      case (dec_class)
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM:
            dec_imm32 = {{20{io.inst[31]}}, io.inst[31:20]};
         OPC_STORE:
            dec_imm32 = {{20{io.inst[31]}}, io.inst[31:25], io.inst[11:7]};
         OPC_BRANCH:
            dec_imm32 = {{19{io.inst[31]}}, io.inst[31], io.inst[7], io.inst[30:25],
                         io.inst[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            dec_imm32 = {io.inst[31:12], 12'b0};
         OPC_JAL:
            dec_imm32 = {{11{io.inst[31]}}, io.inst[31], io.inst[19:12], io.inst[20],
                         io.inst[30:21], 1'b0};
         default:
            dec_imm32 = '0;
      endcase
   end

   assign dec_imm  = XLEN'(dec_imm32);
   assign dec_rd   = (dec_class inside {OPC_STORE, OPC_BRANCH, OPC_ILLEGAL}) ? 5'd0 : io.inst[11:7];
   assign dec_f3   = (dec_class == OPC_JAL) ? 3'b000 : f3;
   assign dec_f7b5 = ((dec_class == OPC_OP) || (dec_class == OPC_OP_IMM && f3 == 3'b101))
                     ? io.inst[30] : 1'b0;

   assign io.rs1_sel = (dec_class inside {OPC_LUI, OPC_AUIPC, OPC_JAL}) ? 5'd0 : io.inst[19:15];
   assign io.rs2_sel = io.inst[24:20];

   assign out_valid   = (count_q != 3'd0);
   assign io.in_ready = rst_n & ((count_q < DEPTH_C) | (out_valid & io.out_ready));
   assign push        = io.in_valid & io.in_ready & ~io.flush;
   assign pop         = out_valid & io.out_ready & ~io.flush;

   always_comb begin
      count_d       = count_q;
      head_d        = head_q;
      tail_d        = tail_q;
      illegal_cnt_d = illegal_cnt_q;
      if (io.flush) begin
         count_d = 3'd0;
         head_d  = 2'd0;
         tail_d  = 2'd0;
      end else begin
         count_d = count_q + {2'b00, push} - {2'b00, pop};
         if (pop)  head_d = ptr_inc(head_q);
         if (push) tail_d = ptr_inc(tail_q);
      end
      if (push && dec_class == OPC_ILLEGAL && illegal_cnt_q != 16'hFFFF)
         illegal_cnt_d = illegal_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q       <= 3'd0;
         head_q        <= 2'd0;
         tail_q        <= 2'd0;
         illegal_cnt_q <= 16'd0;
      end else begin
         count_q       <= count_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   // Operands are captured at accept so later register writes leave entries intact.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail_q]   <= io.curr_pc;
         imm_q[tail_q]  <= dec_imm;
         rs1d_q[tail_q] <= io.rs1_data;
         rs2d_q[tail_q] <= io.rs2_data;
         rd_q[tail_q]   <= dec_rd;
         f3_q[tail_q]   <= dec_f3;
         f7b5_q[tail_q] <= dec_f7b5;
         cls_q[tail_q]  <= dec_class;
      end
   end

   // Head fields read as zero whenever the queue is empty, including after reset.
   assign io.out_valid    = out_valid;
   assign io.out_pc       = out_valid ? pc_q[head_q]   : '0;
   assign io.out_imm      = out_valid ? imm_q[head_q]  : '0;
   assign io.out_rs1_data = out_valid ? rs1d_q[head_q] : '0;
   assign io.out_rs2_data = out_valid ? rs2d_q[head_q] : '0;
   assign io.out_rd_sel   = out_valid ? rd_q[head_q]   : 5'd0;
   assign io.out_funct3   = out_valid ? f3_q[head_q]   : 3'd0;
   assign io.out_funct7b5 = out_valid ? f7b5_q[head_q] : 1'b0;
   assign io.out_opclass  = out_valid ? cls_q[head_q]  : 4'd0;
   assign io.illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Bench for instruction_decode_queue: a queue-level reference model checked every
// cycle, plus hand-computed expectations for specific encodings and events.
module tb_instruction_decode_queue;

   // Handshake: a side transfers on a cycle where its valid and ready are both
   // high at the rising edge; flush overrides both transfers in its cycle.

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] rf [32];

   instruction_decode_queue_if #(.XLEN(32)) bus0 ();
   instruction_decode_queue_if #(.XLEN(32)) bus1 ();

   instruction_decode_queue #(.XLEN(32), .DEPTH(2), .RV_M(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .io(bus0));
   instruction_decode_queue #(.XLEN(32), .DEPTH(2), .RV_M(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .io(bus1));

   assign bus0.rs1_data = rf[bus0.rs1_sel];
   assign bus0.rs2_data = rf[bus0.rs2_sel];
   assign bus1.rs1_data = rf[bus1.rs1_sel];
   assign bus1.rs2_data = rf[bus1.rs2_sel];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc, imm, rs1d, rs2d;
      logic [4:0]  rd, rs1sel, rs2sel;
      logic [2:0]  f3;
      logic        f7b5;
      logic [3:0]  cls;
   } exp_t;

   exp_t        mq [$];
   logic [15:0] mcnt;

   function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc);
      exp_t e;
      int   s;
      s = $signed(i);
      e.pc = pc;
      e.rs1d = '0;
      e.rs2d = '0;
      if (i[1:0] != 2'b11) e.cls = 4'd15;
      else begin
         case (i[6:0])
            7'h33: e.cls = (i[31:25] == 7'h00 ||
                            (i[31:25] == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5)))
                           ? 4'd0 : 4'd15;
            7'h13: e.cls = 4'd1;
            7'h37: e.cls = 4'd2;
            7'h17: e.cls = 4'd3;
            7'h6F: e.cls = 4'd4;
            7'h67: e.cls = 4'd5;
            7'h63: e.cls = 4'd6;
            7'h03: e.cls = 4'd7;
            7'h23: e.cls = 4'd8;
            7'h0F: e.cls = 4'd9;
            7'h73: e.cls = 4'd10;
            default: e.cls = 4'd15;
         endcase
      end
      case (e.cls)
         4'd1, 4'd5, 4'd7, 4'd10: e.imm = 32'(s >>> 20);
         4'd8: e.imm = 32'((s >>> 25) << 5) | 32'(i[11:7]);
         4'd6: e.imm = 32'((s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                       | (32'(i[11:8]) << 1);
         4'd2, 4'd3: e.imm = i & 32'hFFFF_F000;
         4'd4: e.imm = 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                       | (32'(i[30:21]) << 1);
         default: e.imm = 32'd0;
      endcase
      e.rd     = (e.cls == 4'd6 || e.cls == 4'd8 || e.cls == 4'd15) ? 5'd0 : i[11:7];
      e.rs1sel = (e.cls == 4'd2 || e.cls == 4'd3 || e.cls == 4'd4) ? 5'd0 : i[19:15];
      e.rs2sel = i[24:20];
      e.f3     = (e.cls == 4'd4) ? 3'd0 : i[14:12];
      e.f7b5   = (e.cls == 4'd0 || (e.cls == 4'd1 && i[14:12] == 3'd5)) ? i[30] : 1'b0;
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      bit   rdy;
      if (!rst_n) begin
         mq.delete();
         mcnt = 16'd0;
      end else if (bus0.flush) begin
         mq.delete();
      end else begin
         rdy = (mq.size() < 2) || (mq.size() > 0 && bus0.out_ready);
         e = model_decode(bus0.inst, bus0.curr_pc);
         e.rs1d = rf[e.rs1sel];
         e.rs2d = rf[e.rs2sel];
         if (mq.size() > 0 && bus0.out_ready) void'(mq.pop_front());
         if (bus0.in_valid && rdy) begin
            mq.push_back(e);
            if (e.cls == 4'd15 && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("in_ready", bus0.in_ready,
             64'((mq.size() < 2) || (mq.size() > 0 && bus0.out_ready)));
         chk("out_valid", bus0.out_valid, 64'(mq.size() > 0));
         chk("illegal_cnt", bus0.illegal_cnt, mcnt);
         if (mq.size() > 0) begin
            chk("head_pc", bus0.out_pc, mq[0].pc);
            chk("head_imm", bus0.out_imm, mq[0].imm);
            chk("head_rs1d", bus0.out_rs1_data, mq[0].rs1d);
            chk("head_rs2d", bus0.out_rs2_data, mq[0].rs2d);
            chk("head_rd", bus0.out_rd_sel, mq[0].rd);
            chk("head_f3", bus0.out_funct3, mq[0].f3);
            chk("head_f7b5", bus0.out_funct7b5, mq[0].f7b5);
            chk("head_cls", bus0.out_opclass, mq[0].cls);
         end
         if (bus0.in_valid) begin
            e = model_decode(bus0.inst, bus0.curr_pc);
            chk("rs1_sel", bus0.rs1_sel, e.rs1sel);
            chk("rs2_sel", bus0.rs2_sel, e.rs2sel);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_check(input string nm, input logic [31:0] i, input logic [31:0] pc,
                             input logic [3:0] cls, input logic [31:0] imm,
                             input logic [4:0] rd);
      bus0.out_ready = 1'b1;
      bus0.in_valid  = 1'b1;
      bus0.inst      = i;
      bus0.curr_pc   = pc;
      tick();
      bus0.in_valid = 1'b0;
      chk({nm, "_valid"}, bus0.out_valid, 1);
      chk({nm, "_cls"}, bus0.out_opclass, cls);
      chk({nm, "_imm"}, bus0.out_imm, imm);
      chk({nm, "_rd"}, bus0.out_rd_sel, rd);
      chk({nm, "_pc"}, bus0.out_pc, pc);
      tick();
   endtask

   logic [31:0] tbl [12] = '{
      32'h4020D1B3, 32'h40315093, 32'h123452B7, 32'hFFFFF317,
      32'hFF9FF0EF, 32'h00008067, 32'h0020A623, 32'h00000073,
      32'h0FF0000F, 32'h40209033, 32'h04208033, 32'h0000007F
   };

   // ---------------- directed sequence ----------------
   initial begin
      for (int r = 0; r < 32; r++) rf[r] = 32'hA000_0000 + 32'(r) * 32'h111;
      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.inst = '0; bus0.curr_pc = '0;
      bus0.flush = 1'b0;    bus0.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.inst = '0; bus1.curr_pc = '0;
      bus1.flush = 1'b0;    bus1.out_ready = 1'b1;
      tick(); tick();
      chk("rst_in_ready", bus0.in_ready, 0);
      chk("rst_out_valid", bus0.out_valid, 0);
      chk("rst_illegal_cnt", bus0.illegal_cnt, 0);
      rst_n = 1'b1;
      tick();

      push_check("addi", 32'h00500093, 32'h100, 4'd1, 32'h5, 5'd1);
      push_check("beq", 32'hFE000EE3, 32'h104, 4'd6, 32'hFFFF_FFFC, 5'd0);

      bus0.in_valid = 1'b1; bus0.inst = 32'h02208033; bus0.curr_pc = 32'h108;
      bus1.in_valid = 1'b1; bus1.inst = 32'h02208033; bus1.curr_pc = 32'h108;
      tick();
      bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
      chk("mul_m0_cls", bus0.out_opclass, 15);
      chk("mul_m0_cnt", bus0.illegal_cnt, 1);
      chk("mul_m1_cls", bus1.out_opclass, 11);
      chk("mul_m1_cnt", bus1.illegal_cnt, 0);
      chk("mul_m1_rd", bus1.out_rd_sel, 0);
      tick();

      push_check("lui", 32'h123452B7, 32'h10C, 4'd2, 32'h1234_5000, 5'd5);
      push_check("sw", 32'h0020A623, 32'h110, 4'd8, 32'hC, 5'd0);
      push_check("jal", 32'hFF9FF0EF, 32'h114, 4'd4, 32'hFFFF_FFF8, 5'd1);
      push_check("lb", 32'hFFC10283, 32'h118, 4'd7, 32'hFFFF_FFFC, 5'd5);
      push_check("cinst", 32'h00004501, 32'h11C, 4'd15, 32'h0, 5'd0);
      chk("cinst_cnt", bus0.illegal_cnt, 2);

      // Back-pressure: third offer stalls, then push and pop share a cycle.
      bus0.out_ready = 1'b0;
      bus0.in_valid = 1'b1; bus0.inst = 32'h002081B3; bus0.curr_pc = 32'h200;
      tick();
      rf[1] = 32'hDEAD_0001;
      bus0.inst = 32'h40118233; bus0.curr_pc = 32'h204;
      tick();
      bus0.inst = 32'h00812283; bus0.curr_pc = 32'h208;
      #1;
      chk("stall_in_ready", bus0.in_ready, 0);
      tick();
      chk("stall_head_pc", bus0.out_pc, 32'h200);
      bus0.out_ready = 1'b1;
      #1;
      chk("pushpop_in_ready", bus0.in_ready, 1);
      tick();
      bus0.in_valid = 1'b0;
      chk("pushpop_head_pc", bus0.out_pc, 32'h204);
      chk("pushpop_valid", bus0.out_valid, 1);
      tick();
      chk("order_head_pc", bus0.out_pc, 32'h208);
      tick(); tick();

      // Mixed table with irregular valid/ready and register-file churn.
      for (int i = 0; i < 12; i++) begin
         bus0.in_valid  = (i % 4 != 3);
         bus0.out_ready = (i % 3 != 1);
         bus0.inst      = tbl[i];
         bus0.curr_pc   = 32'h300 + 32'(i) * 32'd4;
         rf[(i % 6) + 1] = rf[(i % 6) + 1] ^ 32'h5A5A_0000;
         tick();
      end
      bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
      tick(); tick(); tick();

      // Flush with two entries queued and a third offered.
      bus0.out_ready = 1'b0;
      bus0.in_valid = 1'b1; bus0.inst = 32'h002081B3; bus0.curr_pc = 32'h500;
      tick();
      bus0.inst = 32'h4020D1B3; bus0.curr_pc = 32'h504;
      tick();
      bus0.flush = 1'b1; bus0.inst = 32'h00500093; bus0.curr_pc = 32'h508;
      tick();
      bus0.flush = 1'b0; bus0.in_valid = 1'b0;
      chk("flush_out_valid", bus0.out_valid, 0);
      chk("flush_in_ready", bus0.in_ready, 1);
      bus0.out_ready = 1'b1;
      tick();
      chk("flush_no_offer", bus0.out_valid, 0);

      // Reset with a full queue.
      bus0.out_ready = 1'b0;
      bus0.in_valid = 1'b1; bus0.inst = 32'h0000007F; bus0.curr_pc = 32'h600;
      tick();
      bus0.inst = 32'h00500093; bus0.curr_pc = 32'h604;
      tick();
      bus0.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("rst2_out_valid", bus0.out_valid, 0);
      chk("rst2_in_ready", bus0.in_ready, 0);
      chk("rst2_illegal_cnt", bus0.illegal_cnt, 0);
      chk("rst2_pc", bus0.out_pc, 0);
      chk("rst2_imm", bus0.out_imm, 0);
      chk("rst2_rs1d", bus0.out_rs1_data, 0);
      chk("rst2_rs2d", bus0.out_rs2_data, 0);
      chk("rst2_rd", bus0.out_rd_sel, 0);
      chk("rst2_f3", bus0.out_funct3, 0);
      chk("rst2_f7b5", bus0.out_funct7b5, 0);
      chk("rst2_cls", bus0.out_opclass, 0);
      rst_n = 1'b1;
      bus0.in_valid = 1'b1; bus0.inst = 32'h40315093; bus0.curr_pc = 32'h700;
      tick();
      bus0.in_valid = 1'b0;
      chk("post_rst_valid", bus0.out_valid, 1);
      chk("post_rst_pc", bus0.out_pc, 32'h700);
      chk("post_rst_f7b5", bus0.out_funct7b5, 1);
      bus0.out_ready = 1'b1;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_decode_queue.md
INSTRUCTION_DECODE_QUEUE -- requirements
Module: instruction_decode_queue

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 2, number of output queue entries; legal range is 1..4.
REQ-003 Parameter RV_M, default 0; when 1, M-extension (MUL/DIV) encodings decode as legal.
REQ-004 Port clk, input, 1 bit, single clock, all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit, reset is synchronous and active-low.
REQ-006 Port in_valid, input, 1 bit, fetch offers inst/pc.
REQ-007 Port in_ready, output, 1 bit, block accepts this cycle.
REQ-008 Port inst, input, 32 bits, raw instruction.
REQ-009 Port curr_pc, input, XLEN bits, PC of inst.
REQ-010 Port rs1_sel / rs2_sel, output, 5 bits each, combinational register-file read addresses.
REQ-011 Port rs1_data / rs2_data, input, XLEN bits each, register-file read data, same cycle as rs*_sel.
REQ-012 Port flush, input, 1 bit, discard all queued and offered instructions.
REQ-013 Port out_valid, output, 1 bit, head entry valid.
REQ-014 Port out_ready, input, 1 bit, execute consumes the head.
REQ-015 Port out_pc, out_imm, out_rs1_data, out_rs2_data, output, XLEN bits each, head fields.
REQ-016 Port out_rd_sel, output, 5 bits; out_funct3, output, 3 bits; out_funct7b5, output, 1 bit.
REQ-017 Port out_opclass, output, 4 bits, decoded class of the head entry.
REQ-018 Port illegal_cnt, output, 16 bits, saturating count of illegal instructions accepted.

Function
REQ-019 Accept = in_valid & in_ready & !flush; in_ready = (count < DEPTH) | (out_valid & out_ready).
REQ-020 An accepted instruction appears at the head no earlier than the next cycle; with an empty queue, out_valid rises exactly 1 cycle after accept.
REQ-021 Pop = out_valid & out_ready; push and pop in the same cycle are both performed, and count is unchanged.
REQ-022 The queue is in-order; head/tail pointers wrap modulo DEPTH; outputs are held stable while out_valid & !out_ready.
REQ-023 flush: count, head, and tail are cleared at the next edge, out_valid is 0 the following cycle, and any push or pop in the flush cycle is discarded.
REQ-024 out_opclass encoding: 0 OP, 1 OP_IMM, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 LOAD, 8 STORE, 9 MISC_MEM, 10 SYSTEM, 11 MULDIV, 15 ILLEGAL.
REQ-025 ILLEGAL classification, any of:
  - inst[1:0] != 2'b11;
  - unknown opcode;
  - OP with funct7 not in {0x00, 0x20};
  - funct7 0x20 with funct3 not in {000, 101};
  - funct7 0x01 when RV_M = 0.
REQ-026 MULDIV classification: OP with funct7 0x01 when RV_M = 1.
REQ-027 rs1_sel = 0 for LUI, AUIPC, and JAL; otherwise inst[19:15]. rs2_sel = inst[24:20].
REQ-028 out_rd_sel = 0 for STORE, BRANCH, and ILLEGAL; otherwise inst[11:7].
REQ-029 Immediate formats, sign-extended from inst[31] to XLEN:
  - I for JALR, LOAD, OP_IMM, SYSTEM;
  - S for STORE; B for BRANCH (bit0 = 0); U for LUI, AUIPC (low 12 bits 0); J for JAL (bit0 = 0);
  - all other classes use 0.
REQ-030 out_funct3 = 000 for JAL; otherwise inst[14:12]. out_funct7b5 = inst[30] for OP and for OP_IMM with funct3 101; otherwise 0.
REQ-031 rs1_data and rs2_data are captured into the entry at accept; later register-file changes do not alter queued entries.
REQ-032 illegal_cnt increments by 1 per accepted ILLEGAL entry, saturates at 0xFFFF, and is not cleared by flush.

Reset
REQ-033 While rst_n = 0 at an edge: count, pointers, and illegal_cnt are cleared to 0; out_valid is 0; all out_* data outputs are 0.
REQ-034 in_ready is 0 during any cycle in which rst_n = 0; reset mid-transfer drops all entries without popping them.

Verification
REQ-035 Push inst 0x00500093 (addi x1,x0,5) at pc 0x100 with an empty queue, out_ready=1:
  - next cycle: out_valid=1, opclass=1, imm=5, rd=1, pc=0x100.
REQ-036 DEPTH=2, out_ready=0, push 3 instructions: the third stalls (in_ready=0). Then set out_ready=1 with in_valid=1:
  - push and pop occur in the same cycle; order is preserved.
REQ-037 Push 0xFE000EE3 (beq x0,x0,-4): out_imm=0xFFFFFFFC, opclass=6, rd_sel=0.
REQ-038 RV_M=0: push 0x02208033 (mul) -> opclass=15, illegal_cnt=1. RV_M=1: same inst -> opclass=11, illegal_cnt=0.
REQ-039 Queue holding 2 entries, assert flush together with in_valid=1:
  - next cycle: out_valid=0, count=0;
  - the offered instruction never appears at the head.
REQ-040 Fill the queue, then assert rst_n=0 for 1 cycle:
  - out_valid=0, illegal_cnt=0, all data outputs 0;
  - the first push after release appears at the head 1 cycle later.
